// File: rtl/uart_imem_loader_if.sv
// Byte-stream, control and fetch signals of the UART instruction-memory loader.
// The master side is the UART receiver and CPU; the slave side is the loader.
interface uart_imem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              enable;
    logic              clear;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] out_instruction;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              full;
    logic              overflow;
    logic              timeout_err;

    modport master (
        output rx_valid, rx_byte, enable, clear, address,
        input  out_instruction, word_count, busy, full, overflow, timeout_err
    );

    modport slave (
        input  rx_valid, rx_byte, enable, clear, address,
        output out_instruction, word_count, busy, full, overflow, timeout_err
    );
endinterface

// File: rtl/uart_imem_loader.sv
// Instruction memory filled from a UART byte stream. Bytes are packed into
// DATA_W-bit words (selectable byte order) and written to consecutive
// addresses; the fetch port reads the array combinationally.
module uart_imem_loader #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int BIG_ENDIAN  = 1,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                 CLOCK_50,
    input  logic                 button,
    uart_imem_loader_if.slave    bus
);
    localparam int BPW    = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_next;
    logic [IDLE_W-1:0] idle_cnt;
    logic [ADDR_W:0]   word_count_q;
    logic              overflow_q;
    logic              timeout_q;
    logic              accept;
    logic              last_byte;
    logic              is_full;
    logic              is_busy;
    logic              do_write;
    logic              tmo_hit;

    assign accept    = bus.rx_valid & bus.enable & button & ~bus.clear;
    assign last_byte = (byte_cnt == CNT_W'(BPW - 1));
    assign is_full   = (word_count_q == FULL_CNT);
    assign is_busy   = (byte_cnt != '0);
    assign do_write  = accept & last_byte & ~is_full;
    assign tmo_hit   = (TIMEOUT_CYC > 0) && is_busy && bus.enable && !accept &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    // Place the incoming byte into its lane of the assembly word.
    always_comb begin
        asm_next = asm_q;
        for (int unsigned k = 0; k < BPW; k++) begin
            if (byte_cnt == CNT_W'(k)) begin
                if (BIG_ENDIAN != 0)
                    asm_next[DATA_W-1-8*k -: 8] = bus.rx_byte;
                else
                    asm_next[8*k +: 8] = bus.rx_byte;
            end
        end
    end

    // Byte packing, word counting, timeout and sticky error flags.
    always_ff @(posedge CLOCK_50) begin
        if (!button) begin
            byte_cnt     <= '0;
            asm_q        <= '0;
            idle_cnt     <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else if (bus.clear) begin
            byte_cnt     <= '0;
            asm_q        <= '0;
            idle_cnt     <= '0;
            word_count_q <= '0;
        end else if (accept) begin
            idle_cnt <= '0;
            if (last_byte) begin
                byte_cnt <= '0;
                if (is_full)
                    overflow_q <= 1'b1;
                else
                    word_count_q <= word_count_q + 1'b1;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
                asm_q    <= asm_next;
            end
        end else if (tmo_hit) begin
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            timeout_q <= 1'b1;
        end else if ((TIMEOUT_CYC > 0) && is_busy && bus.enable) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Memory array: no reset so loaded code survives reset and clear.
    // The write address is the word count, which stops advancing once full.
    always_ff @(posedge CLOCK_50) begin
        if (do_write)
            mem[word_count_q[ADDR_W-1:0]] <= asm_next;
    end

    assign bus.out_instruction = mem[bus.address];
    assign bus.word_count      = word_count_q;
    assign bus.busy            = is_busy;
    assign bus.full            = is_full;
    assign bus.overflow        = overflow_q;
    assign bus.timeout_err     = timeout_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench: three loader configurations share one stimulus stream
// and are compared every cycle against a byte-list reference model.
module tb_uart_imem_loader;
    logic       clk = 1'b0;
    logic       button, rx_valid, enable, clear;
    logic [7:0] rx_byte;
    logic [7:0] address;

    always #5 clk = ~clk;

    uart_imem_loader_if #(.DATA_W(32), .ADDR_W(2)) if_a ();
    uart_imem_loader_if #(.DATA_W(32), .ADDR_W(2)) if_b ();
    uart_imem_loader_if #(.DATA_W(16), .ADDR_W(4)) if_c ();

    assign if_a.rx_valid = rx_valid;  assign if_b.rx_valid = rx_valid;  assign if_c.rx_valid = rx_valid;
    assign if_a.rx_byte  = rx_byte;   assign if_b.rx_byte  = rx_byte;   assign if_c.rx_byte  = rx_byte;
    assign if_a.enable   = enable;    assign if_b.enable   = enable;    assign if_c.enable   = enable;
    assign if_a.clear    = clear;     assign if_b.clear    = clear;     assign if_c.clear    = clear;
    assign if_a.address  = address[1:0];
    assign if_b.address  = address[1:0];
    assign if_c.address  = address[3:0];

    uart_imem_loader #(.DATA_W(32), .ADDR_W(2), .BIG_ENDIAN(1), .TIMEOUT_CYC(100))
        u_a (.CLOCK_50(clk), .button(button), .bus(if_a));
    uart_imem_loader #(.DATA_W(32), .ADDR_W(2), .BIG_ENDIAN(0), .TIMEOUT_CYC(0))
        u_b (.CLOCK_50(clk), .button(button), .bus(if_b));
    uart_imem_loader #(.DATA_W(16), .ADDR_W(4), .BIG_ENDIAN(1), .TIMEOUT_CYC(5))
        u_c (.CLOCK_50(clk), .button(button), .bus(if_c));

    localparam int C_BPW   [3] = '{4, 4, 2};
    localparam int C_DEPTH [3] = '{4, 4, 16};
    localparam int C_BE    [3] = '{1, 0, 1};
    localparam int C_TMO   [3] = '{100, 0, 5};

    // Reference model state
    int          m_wc   [3];
    bit          m_ovf  [3];
    bit          m_terr [3];
    logic [7:0]  m_pb   [3][4];
    int          m_pn   [3];
    int          m_idle [3];
    logic [31:0] m_mem  [3][16];
    bit          m_wr   [3][16];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] b;
        int         wc;
        logic       busy;
        logic       full;
        logic       ovf;
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %h expected %h", name, i, act, exp);
        end
    endtask

    // Apply one clock of the current inputs to the model of instance i.
    task automatic model_update(input int i);
        logic [31:0] word;
        if (!button) begin
            m_wc[i] = 0; m_ovf[i] = 0; m_terr[i] = 0; m_pn[i] = 0; m_idle[i] = 0;
            return;
        end
        if (clear) begin
            m_wc[i] = 0; m_pn[i] = 0; m_idle[i] = 0;
            return;
        end
        if (rx_valid && enable) begin
            m_pb[i][m_pn[i]] = rx_byte;
            m_pn[i]++;
            m_idle[i] = 0;
            if (m_pn[i] == C_BPW[i]) begin
                word = '0;
                for (int k = 0; k < C_BPW[i]; k++) begin
                    if (C_BE[i] != 0) word = (word << 8) | 32'(m_pb[i][k]);
                    else              word = word | (32'(m_pb[i][k]) << (8 * k));
                end
                m_pn[i] = 0;
                if (m_wc[i] == C_DEPTH[i]) m_ovf[i] = 1;
                else begin
                    m_mem[i][m_wc[i]] = word;
                    m_wr[i][m_wc[i]]  = 1;
                    m_wc[i]++;
                end
            end
        end else if (enable && m_pn[i] > 0 && C_TMO[i] > 0) begin
            m_idle[i]++;
            if (m_idle[i] == C_TMO[i]) begin
                m_pn[i] = 0; m_idle[i] = 0; m_terr[i] = 1;
            end
        end
    endtask

    task automatic check_model(input int i, input logic [31:0] wc, input logic [31:0] busy,
                               input logic [31:0] full, input logic [31:0] ovf,
                               input logic [31:0] terr, input logic [31:0] out);
        int a;
        a = int'(address) % C_DEPTH[i];
        chk("word_count", i, wc, 32'(m_wc[i]));
        chk("busy", i, busy, 32'(m_pn[i] != 0));
        chk("full", i, full, 32'(m_wc[i] == C_DEPTH[i]));
        chk("overflow", i, ovf, 32'(m_ovf[i]));
        chk("timeout_err", i, terr, 32'(m_terr[i]));
        if (m_wr[i][a]) chk("out_instruction", i, out, m_mem[i][a]);
    endtask

    task automatic cycle();
        for (int i = 0; i < 3; i++) model_update(i);
        @(posedge clk);
        #1;
        check_model(0, 32'(if_a.word_count), 32'(if_a.busy), 32'(if_a.full),
                    32'(if_a.overflow), 32'(if_a.timeout_err), 32'(if_a.out_instruction));
        check_model(1, 32'(if_b.word_count), 32'(if_b.busy), 32'(if_b.full),
                    32'(if_b.overflow), 32'(if_b.timeout_err), 32'(if_b.out_instruction));
        check_model(2, 32'(if_c.word_count), 32'(if_c.busy), 32'(if_c.full),
                    32'(if_c.overflow), 32'(if_c.timeout_err), 32'(if_c.out_instruction));
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        cycle();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int j = 0; j < 4; j++) send(w[31-8*j -: 8]);
    endtask

    task automatic peek_a(input string name, input logic [7:0] addr, input logic [31:0] exp);
        address = addr;
        #1;
        chk(name, 0, 32'(if_a.out_instruction), exp);
    endtask

    initial begin
        logic [31:0] words [3];
        int rate;

        tbl[0]  = '{8'h12, 0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'h34, 0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{8'h56, 0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{8'h78, 1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'h9A, 1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{8'hBC, 1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{8'hDE, 1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{8'hF0, 2, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h11, 2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{8'h22, 2, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{8'h33, 2, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{8'h44, 3, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{8'h55, 3, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{8'h66, 3, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{8'h77, 3, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{8'h88, 4, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{8'hAA, 4, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{8'hBB, 4, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{8'hCC, 4, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{8'hDD, 4, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 3; i++) begin
            m_wc[i] = 0; m_ovf[i] = 0; m_terr[i] = 0; m_pn[i] = 0; m_idle[i] = 0;
            for (int a = 0; a < 16; a++) begin m_mem[i][a] = '0; m_wr[i][a] = 0; end
        end

        button = 1'b0; rx_valid = 1'b0; rx_byte = '0; enable = 1'b1; clear = 1'b0; address = '0;
        cycle();
        cycle();
        chk("rst_word_count", 0, 32'(if_a.word_count), 32'd0);
        chk("rst_busy", 0, 32'(if_a.busy), 32'd0);
        chk("rst_full", 0, 32'(if_a.full), 32'd0);
        chk("rst_overflow", 0, 32'(if_a.overflow), 32'd0);
        chk("rst_timeout", 0, 32'(if_a.timeout_err), 32'd0);
        button = 1'b1;

        // Fill to full and one beyond on the 4-deep instances
        for (int n = 0; n < 20; n++) begin
            send(tbl[n].b);
            chk("tbl_word_count", 0, 32'(if_a.word_count), 32'(tbl[n].wc));
            chk("tbl_busy", 0, 32'(if_a.busy), 32'(tbl[n].busy));
            chk("tbl_full", 0, 32'(if_a.full), 32'(tbl[n].full));
            chk("tbl_overflow", 0, 32'(if_a.overflow), 32'(tbl[n].ovf));
        end
        peek_a("be_word0", 8'd0, 32'h12345678);
        peek_a("be_word3", 8'd3, 32'h55667788);
        chk("le_word0", 1, 32'(if_b.out_instruction), 32'h55667788 == 32'h0 ? 32'h0 : 32'h88776655);
        address = 8'd0;
        #1;
        chk("le_word0", 1, 32'(if_b.out_instruction), 32'h78563412);
        chk("w16_word0", 2, 32'(if_c.out_instruction), 32'h00001234);
        chk("w16_count", 2, 32'(if_c.word_count), 32'd10);

        // clear in the same cycle as a byte mid-word
        send(8'hA1);
        send(8'hA2);
        rx_valid = 1'b1; rx_byte = 8'hA3; clear = 1'b1;
        cycle();
        rx_valid = 1'b0; clear = 1'b0;
        chk("clr_busy", 0, 32'(if_a.busy), 32'd0);
        chk("clr_word_count", 0, 32'(if_a.word_count), 32'd0);
        chk("clr_overflow_sticky", 0, 32'(if_a.overflow), 32'd1);
        peek_a("clr_mem_kept", 8'd0, 32'h12345678);

        // enable low freezes a partial word, ignoring strobes
        send(8'h01);
        enable = 1'b0; rx_valid = 1'b1; rx_byte = 8'hEE;
        repeat (150) cycle();
        rx_valid = 1'b0; enable = 1'b1;
        chk("frz_busy", 0, 32'(if_a.busy), 32'd1);
        chk("frz_timeout", 0, 32'(if_a.timeout_err), 32'd0);
        send(8'h02); send(8'h03); send(8'h04);
        peek_a("frz_word", 8'd0, 32'h01020304);

        // inter-byte timeout boundary
        clear = 1'b1; cycle(); clear = 1'b0;
        send(8'h55); send(8'h66);
        repeat (99) cycle();
        chk("tmo_busy_99", 0, 32'(if_a.busy), 32'd1);
        chk("tmo_err_99", 0, 32'(if_a.timeout_err), 32'd0);
        cycle();
        chk("tmo_busy_100", 0, 32'(if_a.busy), 32'd0);
        chk("tmo_err_100", 0, 32'(if_a.timeout_err), 32'd1);
        send_word(32'hDEADBEEF);
        peek_a("tmo_word", 8'd0, 32'hDEADBEEF);

        // reset after three words and mid-word
        clear = 1'b1; cycle(); clear = 1'b0;
        words[0] = 32'hC0FFEE00; words[1] = 32'h0BADF00D; words[2] = 32'hFEEDFACE;
        for (int w = 0; w < 3; w++) send_word(words[w]);
        send(8'h99);
        button = 1'b0; cycle(); button = 1'b1;
        chk("rst2_word_count", 0, 32'(if_a.word_count), 32'd0);
        chk("rst2_busy", 0, 32'(if_a.busy), 32'd0);
        chk("rst2_overflow", 0, 32'(if_a.overflow), 32'd0);
        chk("rst2_timeout", 0, 32'(if_a.timeout_err), 32'd0);
        for (int w = 0; w < 3; w++) peek_a("rst2_mem", 8'(w), words[w]);
        send_word(32'hABCD1234);
        peek_a("rst2_next_at_0", 8'd0, 32'hABCD1234);
        chk("w16_abcd", 2, 32'(if_c.out_instruction), 32'h0000ABCD);

        // randomized traffic, alternating dense and sparse byte rates
        for (int p = 0; p < 6; p++) begin
            rate = (p % 2 == 0) ? 50 : 2;
            for (int n = 0; n < 500; n++) begin
                rx_valid = ($urandom_range(0, 99) < rate);
                rx_byte  = 8'($urandom);
                enable   = ($urandom_range(0, 19) != 0);
                clear    = ($urandom_range(0, 149) == 0);
                button   = ($urandom_range(0, 299) != 0);
                address  = 8'($urandom);
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
